// File: rtl/bsg_rocket_pkg.sv
// rtl/bsg_rocket_pkg.sv - shared NASTI / tunnel packet types and error-bit indices
package bsg_rocket_pkg;

    localparam int nasti_id_width_lp   = 5;
    localparam int nasti_data_width_lp = 64;
    localparam int tun_dmx_width_lp    = 80;

    typedef struct packed {
        logic [nasti_id_width_lp-1:0]   id;
        logic [nasti_data_width_lp-1:0] data;
        logic [1:0]                     resp;
        logic                           last;
    } bsg_nasti_r_pkt;

    typedef struct packed {
        logic                           last;
        logic [nasti_data_width_lp-1:0] data;
        logic [nasti_id_width_lp-1:0]   id;
    } bsg_nasti_sr_pkt;

    typedef logic [tun_dmx_width_lp-1:0] bsg_tun_dmx_t;

    localparam int err_resp_lp = 0;
    localparam int err_len_lp  = 1;
    localparam int err_id_lp   = 2;

    function automatic bsg_nasti_sr_pkt nasti_r_to_sr(input bsg_nasti_r_pkt r);
        bsg_nasti_sr_pkt sr;
        sr.last = r.last;
        sr.data = r.data;
        sr.id   = r.id;
        return sr;
    endfunction

endpackage

// File: rtl/bsg_two_fifo.sv
// rtl/bsg_two_fifo.sv - two-entry FIFO with registered ready/valid
module bsg_two_fifo #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem_r [2];
    logic               wptr_r;
    logic               rptr_r;
    logic [1:0]         count_r;
    logic               enq;
    logic               deq;

    // Flags come straight from count_r so ready/valid never see same-cycle inputs.
    assign ready_o = (count_r != 2'd2);
    assign v_o     = (count_r != 2'd0);
    assign data_o  = mem_r[rptr_r];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r  <= 1'b0;
            rptr_r  <= 1'b0;
            count_r <= 2'd0;
        end else begin
            if (enq) wptr_r <= ~wptr_r;
            if (deq) rptr_r <= ~rptr_r;
            count_r <= count_r + {1'b0, enq} - {1'b0, deq};
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wptr_r] <= data_i;
    end

endmodule

// File: rtl/bsg_nasti_master_resp.sv
// rtl/bsg_nasti_master_resp.sv - NASTI R channel to tunnel response buffer with burst checks
module bsg_nasti_master_resp
    import bsg_rocket_pkg::*;
#(
    parameter int max_beats_p = 8
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           nasti_r_valid_i,
    input  bsg_nasti_r_pkt nasti_r_data_i,
    output logic           nasti_r_ready_o,
    output logic           resp_valid_o,
    output bsg_tun_dmx_t   resp_data_o,
    input  logic           resp_yumi_i,
    output logic [2:0]     error_o
);

    localparam int cnt_w_lp = $clog2(max_beats_p + 1);
    localparam int pad_w_lp = $bits(bsg_tun_dmx_t) - $bits(bsg_nasti_sr_pkt);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic                state_r;
    logic [cnt_w_lp-1:0] cnt_r;
    logic [4:0]          cur_id_r;
    logic [2:0]          error_r;
    logic                reset_r;
    logic                fifo_ready;
    logic                accept;
    bsg_nasti_sr_pkt     fifo_data;

    // Hold ready low for one extra cycle after reset releases.
    always_ff @(posedge clk_i) reset_r <= reset_i;

    assign nasti_r_ready_o = fifo_ready & ~reset_i & ~reset_r;
    assign accept          = nasti_r_valid_i & nasti_r_ready_o;
    assign resp_data_o     = {{pad_w_lp{1'b0}}, fifo_data};
    assign error_o         = error_r;

    bsg_two_fifo #(.width_p($bits(bsg_nasti_sr_pkt))) buf_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (nasti_r_to_sr(nasti_r_data_i)),
        .v_i     (accept),
        .ready_o (fifo_ready),
        .v_o     (resp_valid_o),
        .data_o  (fifo_data),
        .yumi_i  (resp_yumi_i & resp_valid_o)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            cur_id_r <= '0;
            error_r  <= '0;
        end else if (accept) begin
            if (nasti_r_data_i.resp != 2'b00) error_r[err_resp_lp] <= 1'b1;
            if (state_r == IDLE) begin
                if (!nasti_r_data_i.last) begin
                    state_r  <= BURST;
                    cnt_r    <= cnt_w_lp'(1);
                    cur_id_r <= nasti_r_data_i.id;
                end
            end else begin
                if (nasti_r_data_i.id != cur_id_r) error_r[err_id_lp] <= 1'b1;
                if (nasti_r_data_i.last) begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                end else if ((cnt_r + 1'b1) == cnt_w_lp'(max_beats_p)) begin
                    error_r[err_len_lp] <= 1'b1;
                    state_r             <= IDLE;
                    cnt_r               <= '0;
                end else begin
                    cnt_r <= cnt_r + 1'b1;
                end
            end
        end
    end

    yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        !(resp_yumi_i && !resp_valid_o));

endmodule

// File: tb/tb_bsg_nasti_master_resp.sv
// tb/tb_bsg_nasti_master_resp.sv - randomized self-checking bench against a queue-based reference
module tb_bsg_nasti_master_resp;
    import bsg_rocket_pkg::*;

    localparam int MAX = 8;

    logic           clk = 1'b0;
    logic           reset_i = 1'b1;
    logic           r_valid = 1'b0;
    bsg_nasti_r_pkt r_data = '0;
    logic           r_ready;
    logic           resp_valid;
    bsg_tun_dmx_t   resp_data;
    logic           resp_yumi = 1'b0;
    logic [2:0]     error;

    bsg_nasti_master_resp #(.max_beats_p(MAX)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .nasti_r_valid_i (r_valid),
        .nasti_r_data_i  (r_data),
        .nasti_r_ready_o (r_ready),
        .resp_valid_o    (resp_valid),
        .resp_data_o     (resp_data),
        .resp_yumi_i     (resp_yumi),
        .error_o         (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [79:0] exp_q[$];
    logic [2:0]  exp_err;
    int          burst_beats;
    logic [4:0]  burst_id;
    bit          after_rst;
    bit          last_acc;

    task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] expect_word(input bsg_nasti_r_pkt p);
        logic [79:0] w;
        w = '0;
        w[4:0]  = p.id;
        w[68:5] = p.data;
        w[69]   = p.last;
        return w;
    endfunction

    function automatic bsg_nasti_r_pkt mk(input logic [4:0] id, input logic [63:0] d,
                                          input logic [1:0] resp, input logic last);
        bsg_nasti_r_pkt p;
        p.id = id; p.data = d; p.resp = resp; p.last = last;
        return p;
    endfunction

    // Burst rules: a burst opens on a non-last beat; over-long bursts flag and close.
    task automatic model_accept(input bsg_nasti_r_pkt p);
        exp_q.push_back(expect_word(p));
        if (p.resp != 2'b00) exp_err[0] = 1'b1;
        if (burst_beats == 0) begin
            if (!p.last) begin
                burst_beats = 1;
                burst_id    = p.id;
            end
        end else begin
            if (p.id != burst_id) exp_err[2] = 1'b1;
            if (p.last) burst_beats = 0;
            else begin
                burst_beats++;
                if (burst_beats == MAX) begin
                    exp_err[1]  = 1'b1;
                    burst_beats = 0;
                end
            end
        end
    endtask

    task automatic cycle(input logic v, input bsg_nasti_r_pkt p, input logic y);
        bit exp_ready;
        bit deq;
        r_valid   = v;
        r_data    = p;
        resp_yumi = y & resp_valid;
        exp_ready = (exp_q.size() < 2) && !after_rst;
        @(negedge clk);
        check_val("ready", 80'(r_ready), 80'(exp_ready));
        check_val("resp_valid", 80'(resp_valid), 80'(exp_q.size() > 0));
        if (exp_q.size() > 0) check_val("resp_data", resp_data, exp_q[0]);
        check_val("error", 80'(error), 80'(exp_err));
        check_val("fsm_burst", 80'(dut.state_r), 80'(burst_beats != 0));
        last_acc = v && exp_ready;
        deq      = resp_yumi && (exp_q.size() > 0);
        @(posedge clk);
        #1;
        after_rst = 1'b0;
        if (deq) void'(exp_q.pop_front());
        if (last_acc) model_accept(p);
    endtask

    task automatic idle(input int n, input logic y);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, y);
    endtask

    task automatic drive_beat(input bsg_nasti_r_pkt p, input logic y);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, p, y);
            if (last_acc) return;
        end
        check_val("beat_accept_timeout", 80'(0), 80'(1));
    endtask

    task automatic do_reset();
        r_valid   = 1'b0;
        resp_yumi = 1'b0;
        reset_i   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", 80'(r_ready), 80'(0));
        check_val("rst_valid", 80'(resp_valid), 80'(0));
        check_val("rst_error", 80'(error), 80'(0));
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        exp_q.delete();
        exp_err     = '0;
        burst_beats = 0;
        burst_id    = '0;
        after_rst   = 1'b1;
    endtask

    initial begin
        bsg_nasti_r_pkt p;
        do_reset();
        idle(1, 1'b1);

        drive_beat(mk(5'h3, 64'hDEAD_BEEF_0000_0001, 2'b00, 1'b1), 1'b1);
        idle(2, 1'b1);

        for (int i = 0; i < 4; i++)
            drive_beat(mk(5'h1, 64'(i) + 64'h100, 2'b00, i == 3), 1'b1);
        idle(3, 1'b1);

        drive_beat(mk(5'h2, 64'hA, 2'b00, 1'b1), 1'b0);
        drive_beat(mk(5'h2, 64'hB, 2'b00, 1'b1), 1'b0);
        p = mk(5'h2, 64'hC, 2'b00, 1'b1);
        cycle(1'b1, p, 1'b0);
        cycle(1'b1, p, 1'b0);
        drive_beat(p, 1'b1);
        idle(4, 1'b1);

        for (int i = 0; i < MAX; i++) drive_beat(mk(5'h4, 64'(i), 2'b00, 1'b0), 1'b1);
        idle(2, 1'b1);
        drive_beat(mk(5'h4, 64'h55, 2'b10, 1'b1), 1'b1);
        idle(3, 1'b1);

        do_reset();
        idle(1, 1'b1);
        drive_beat(mk(5'h1, 64'h1, 2'b00, 1'b0), 1'b1);
        drive_beat(mk(5'h2, 64'h2, 2'b00, 1'b1), 1'b1);
        idle(2, 1'b1);
        drive_beat(mk(5'h6, 64'h6, 2'b00, 1'b1), 1'b0);
        drive_beat(mk(5'h7, 64'h7, 2'b00, 1'b1), 1'b0);
        do_reset();
        idle(2, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            p = mk(5'($urandom_range(0, 2)), {$urandom, $urandom},
                   ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                   $urandom_range(0, 5) == 0);
            cycle($urandom_range(0, 3) != 0, p, $urandom_range(0, 3) != 0);
        end
        idle(4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
